line_mem_responder: RTL

- Memory-side responder for the D-cache line interface: services 128-bit line reads (refill) and line writes (write-back) requested via mem_r/mem_w/mem_addr.
- Converts each line transfer into four 32-bit beats on a synchronous word RAM with programmable per-beat wait states.
- Signals completion to the cache with a single-cycle mem_ready pulse.
- Sits between D_cache and the data RAM.

---
 rtl/line_mem_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - D-cache line read/write responder over a 32-bit word RAM
//
// Services 128-bit line refills (mem_r) and write-backs (mem_w) as four
// 32-bit beats on a synchronous word RAM, with WAIT_CYCLES idle cycles before
// each beat, and completes with a one-cycle mem_ready pulse.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   mem_r, mem_w        line read / write request, held until mem_ready
//   mem_addr            line byte address, bits [3:0] ignored
//   mem_data_out        write line from cache, word k = bits [32k+31:32k]
//   mem_data            read line to cache, same packing
//   mem_ready           one-cycle completion pulse
//   mem_err             out-of-range access flag (MEM_BOUNDS_CHK_EN only)
//   ram_addr            RAM word address {line, beat}
//   ram_wdata, ram_we   RAM write word and strobe
//   ram_re, ram_rdata   RAM read strobe and read word (valid the cycle after)
//
// Optional feature macro: MEM_BOUNDS_CHK_EN
module line_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int RAM_AW      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [31:0]       mem_addr,
    input  logic [127:0]      mem_data_out,
    output logic [127:0]      mem_data,
    output logic              mem_ready,
`ifdef MEM_BOUNDS_CHK_EN
    output logic              mem_err,
`endif
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [31:0]       ram_rdata
);

    localparam int         LW        = RAM_AW - 2;
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LAST = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ACCESS, S_DRAIN, S_DONE, S_TURN
    } state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  line_q, line_d;
    logic [127:0]   wline_q, wline_d;
    logic           is_wr_q, is_wr_d;
    logic [1:0]     beat_q, beat_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           cap_vld_q, cap_vld_d;
    logic [1:0]     cap_beat_q, cap_beat_d;
    logic [127:0]   rline_q, rline_d;
    logic           err_q, err_d;

    logic req;
    logic oob;
    logic unused_addr_bits;

    assign req = mem_r | mem_w;
    assign unused_addr_bits = ^{mem_addr[31:RAM_AW+2], mem_addr[3:0]};

`ifdef MEM_BOUNDS_CHK_EN
    assign oob = |mem_addr[31:RAM_AW+2];
`else
    assign oob = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (oob)          state_d = S_DONE;
                    else if (NO_WAIT) state_d = S_ACCESS;
                    else              state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (beat_q == 2'd3) state_d = is_wr_q ? S_DONE : S_DRAIN;
                else                state_d = NO_WAIT ? S_ACCESS : S_WAIT;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_TURN;
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: request latch, beat/wait counters, read capture
    always_comb begin
        line_d     = line_q;
        wline_d    = wline_q;
        is_wr_d    = is_wr_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        cap_vld_d  = 1'b0;
        cap_beat_d = cap_beat_q;
        rline_d    = rline_q;
        err_d      = err_q;

        // Read data arrives one cycle after the strobe; this may overlap
        // the following WAIT/ACCESS cycle, or DRAIN for the last beat.
        if (cap_vld_q) begin
            rline_d[{cap_beat_q, 5'd0} +: 32] = ram_rdata;
        end

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    line_d  = mem_addr[RAM_AW+1:4];
                    wline_d = mem_data_out;
                    is_wr_d = mem_w;       // write wins over a simultaneous read
                    beat_d  = 2'd0;
                    cnt_d   = 4'd0;
                    err_d   = oob;
                    if (oob && !mem_w) rline_d = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
            end
            S_ACCESS: begin
                beat_d = beat_q + 2'd1;
                cnt_d  = 4'd0;
                if (!is_wr_q) begin
                    cap_vld_d  = 1'b1;
                    cap_beat_d = beat_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q     <= '0;
            wline_q    <= '0;
            is_wr_q    <= 1'b0;
            beat_q     <= 2'd0;
            cnt_q      <= 4'd0;
            cap_vld_q  <= 1'b0;
            cap_beat_q <= 2'd0;
            rline_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            line_q     <= line_d;
            wline_q    <= wline_d;
            is_wr_q    <= is_wr_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            cap_vld_q  <= cap_vld_d;
            cap_beat_q <= cap_beat_d;
            rline_q    <= rline_d;
            err_q      <= err_d;
        end
    end

    // Outputs decode straight from state so a reset drops the strobes at once
    always_comb begin
        mem_ready = (state_q == S_DONE);
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state_q == S_ACCESS) begin
            ram_we    = is_wr_q;
            ram_re    = !is_wr_q;
            ram_addr  = {line_q, beat_q};
            ram_wdata = wline_q[{beat_q, 5'd0} +: 32];
        end
    end

    assign mem_data = rline_q;

`ifdef MEM_BOUNDS_CHK_EN
    assign mem_err = mem_ready & err_q;
`endif

endmodule
